// File: rtl/frog_pkg.sv
// Shared types, frog bitmap and the orientation-aware pixel fetch for the frog controller.
// Used by frog_hop_ctrl and frog_sprite_rom.
package frog_pkg;

    typedef enum logic [1:0] {
        FACE_UP = 2'd0,
        FACE_DN = 2'd1,
        FACE_LT = 2'd2,
        FACE_RT = 2'd3
    } facing_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2,
        S_LOCK   = 2'd3
    } state_t;

    // Row r of the upright frog, bit c is column c (column 0 = leftmost pixel).
    localparam logic [31:0] c_FROG_BMP [32] = '{
        32'h03C003C0, 32'h07E007E0, 32'h0FF00FF0, 32'h0E700E70,
        32'h0FF00FF0, 32'h07FFFFE0, 32'h03FFFFC0, 32'h07FFFFE0,
        32'h0FFFFFF0, 32'h1FF00FF8, 32'h1FE007F8, 32'h3FFFFFFC,
        32'h3FFFFFFC, 32'h7FFFFFFE, 32'h7FFFFFFE, 32'h7FF81FFE,
        32'h7FF00FFE, 32'h7FFFFFFE, 32'h3FFFFFFC, 32'h3FFFFFFC,
        32'h1FFFFFF8, 32'h0FFFFFF0, 32'h67FFFFE6, 32'hF3FFFFCF,
        32'hF9FFFF9F, 32'hFCF00F3F, 32'h7E00007E, 32'h3F0000FC,
        32'h1F8001F8, 32'h0F0000F0, 32'h06000060, 32'h00000000
    };

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // i_last is the sprite edge minus one, so flips stay inside smaller sprites.
    function automatic logic f_frog_pixel(input facing_t i_facing,
                                          input logic [4:0] i_r,
                                          input logic [4:0] i_c,
                                          input logic [4:0] i_last);
        logic [4:0] row;
        logic [4:0] col;
        row = i_r;
        col = i_c;
        case (i_facing)
            FACE_UP: begin row = i_r;          col = i_c; end
            FACE_DN: begin row = i_last - i_r; col = i_c; end
            FACE_LT: begin row = i_c;          col = i_r; end
            FACE_RT: begin row = i_last - i_c; col = i_r; end
        endcase
        return c_FROG_BMP[row][col];
    endfunction

endpackage

// File: rtl/frog_sprite_rom.sv
// Registered frog sprite lookup: rotates the bitmap by facing and masks pixels outside the box.
module frog_sprite_rom
    import frog_pkg::*;
#(
    parameter int c_SPRITE_SIZE = 32
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  facing_t    i_Facing,
    input  logic [4:0] i_Row_Ofs,
    input  logic [4:0] i_Col_Ofs,
    input  logic       i_In_Box,
    output logic       o_Pixel
);

    localparam logic [4:0] c_LAST = 5'(c_SPRITE_SIZE - 1);

    logic r_pixel;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_pixel <= 1'b0;
        end else begin
            r_pixel <= i_In_Box & f_frog_pixel(i_Facing, i_Row_Ofs, i_Col_Ofs, c_LAST);
        end
    end

    assign o_Pixel = r_pixel;

endmodule

// File: rtl/frog_hop_ctrl.sv
// Frog player controller: tile hops with typematic repeat, respawn lock and sprite draw.
// Define FROG_WRAP_X_EN to wrap horizontal hops around the playfield instead of clamping.
module frog_hop_ctrl
    import frog_pkg::*;
#(
    parameter int c_GAME_WIDTH    = 640,
    parameter int c_GAME_HEIGHT   = 480,
    parameter int c_SPRITE_SIZE   = 32,
    parameter int c_STEP          = 32,
    parameter int c_START_X       = 304,
    parameter int c_START_Y       = 448,
    parameter int c_HOLD_DELAY    = 12500000,
    parameter int c_REPEAT_PERIOD = 5000000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [9:0] i_Col_Count_Div,
    input  logic [9:0] i_Row_Count_Div,
    input  logic       i_Up,
    input  logic       i_Dn,
    input  logic       i_Lt,
    input  logic       i_Rt,
    input  logic       i_Respawn,
    output logic [9:0] o_Pos_X,
    output logic [9:0] o_Pos_Y,
    output logic [1:0] o_Facing,
    output logic       o_Hop,
    output logic       o_Blocked,
    output logic       o_Draw
);

    localparam int c_CNT_MAX = f_max(c_HOLD_DELAY, c_REPEAT_PERIOD);
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(c_HOLD_DELAY - 1);
    localparam logic [c_CNT_W-1:0] c_REP_LAST  = c_CNT_W'(c_REPEAT_PERIOD - 1);

    localparam logic [10:0] c_STEP_11 = 11'(c_STEP);
    localparam logic [10:0] c_SIZE_11 = 11'(c_SPRITE_SIZE);
    localparam logic [10:0] c_X_MAX   = 11'(c_GAME_WIDTH - c_SPRITE_SIZE);
    localparam logic [10:0] c_Y_MAX   = 11'(c_GAME_HEIGHT - c_SPRITE_SIZE);
`ifdef FROG_WRAP_X_EN
    localparam logic [10:0] c_X_WRAP  = 11'(c_GAME_WIDTH - c_STEP);
`endif
    localparam logic [9:0]  c_X0      = 10'(c_START_X);
    localparam logic [9:0]  c_Y0      = 10'(c_START_Y);

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic [9:0]           r_pos_x;
    logic [9:0]           r_pos_y;
    facing_t              r_facing;
    logic                 r_hop;
    logic                 r_blocked;

    logic [3:0]  w_btn;
    logic        w_any_btn;
    logic        w_req_valid;
    facing_t     w_req_dir;
    logic        w_attempt;
    logic        w_legal;
    logic [9:0]  w_new_x;
    logic [9:0]  w_new_y;
    logic [10:0] w_x11;
    logic [10:0] w_y11;
    logic [10:0] w_col11;
    logic [10:0] w_row11;
    logic [4:0]  w_col_ofs;
    logic [4:0]  w_row_ofs;
    logic        w_in_box;
    logic        w_pixel;

    assign w_btn       = {i_Rt, i_Lt, i_Dn, i_Up};
    assign w_any_btn   = |w_btn;
    assign w_req_valid = $onehot(w_btn);

    always_comb begin
        w_req_dir = FACE_UP;
        case (w_btn)
            4'b0010: w_req_dir = FACE_DN;
            4'b0100: w_req_dir = FACE_LT;
            4'b1000: w_req_dir = FACE_RT;
            default: w_req_dir = FACE_UP;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // r_facing always holds the held direction while in S_HOLD/S_REPEAT,
    // because entering either state requires a hop attempt that sets it.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_attempt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_valid) begin
                    w_attempt    = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!w_req_valid) begin
                    w_cnt_next   = '0;
                    w_state_next = S_IDLE;
                end else if (w_req_dir != r_facing) begin
                    w_attempt  = 1'b1;
                    w_cnt_next = '0;
                end else if (r_cnt == c_HOLD_LAST) begin
                    w_attempt    = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = S_REPEAT;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_REPEAT: begin
                if (!w_req_valid) begin
                    w_cnt_next   = '0;
                    w_state_next = S_IDLE;
                end else if (w_req_dir != r_facing) begin
                    w_attempt    = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = S_HOLD;
                end else if (r_cnt == c_REP_LAST) begin
                    w_attempt  = 1'b1;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_LOCK: begin
                if (!w_any_btn) begin
                    w_cnt_next   = '0;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
        if (i_Respawn) begin
            w_attempt    = 1'b0;
            w_cnt_next   = '0;
            w_state_next = S_LOCK;
        end
    end

    assign w_x11 = {1'b0, r_pos_x};
    assign w_y11 = {1'b0, r_pos_y};

    always_comb begin
        w_legal = 1'b0;
        w_new_x = r_pos_x;
        w_new_y = r_pos_y;
        case (w_req_dir)
            FACE_UP: begin
                if (w_y11 >= c_STEP_11) begin
                    w_legal = 1'b1;
                    w_new_y = 10'(w_y11 - c_STEP_11);
                end
            end
            FACE_DN: begin
                if (w_y11 + c_STEP_11 <= c_Y_MAX) begin
                    w_legal = 1'b1;
                    w_new_y = 10'(w_y11 + c_STEP_11);
                end
            end
`ifdef FROG_WRAP_X_EN
            FACE_LT: begin
                w_legal = 1'b1;
                w_new_x = (w_x11 >= c_STEP_11) ? 10'(w_x11 - c_STEP_11) : 10'(c_X_WRAP);
            end
            FACE_RT: begin
                w_legal = 1'b1;
                w_new_x = (w_x11 >= c_X_WRAP) ? 10'd0 : 10'(w_x11 + c_STEP_11);
            end
`else
            FACE_LT: begin
                if (w_x11 >= c_STEP_11) begin
                    w_legal = 1'b1;
                    w_new_x = 10'(w_x11 - c_STEP_11);
                end
            end
            FACE_RT: begin
                if (w_x11 + c_STEP_11 <= c_X_MAX) begin
                    w_legal = 1'b1;
                    w_new_x = 10'(w_x11 + c_STEP_11);
                end
            end
`endif
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_pos_x   <= c_X0;
            r_pos_y   <= c_Y0;
            r_facing  <= FACE_UP;
            r_hop     <= 1'b0;
            r_blocked <= 1'b0;
        end else begin
            r_hop     <= 1'b0;
            r_blocked <= 1'b0;
            if (i_Respawn) begin
                r_pos_x  <= c_X0;
                r_pos_y  <= c_Y0;
                r_facing <= FACE_UP;
            end else if (w_attempt) begin
                r_facing <= w_req_dir;
                if (w_legal) begin
                    r_pos_x <= w_new_x;
                    r_pos_y <= w_new_y;
                    r_hop   <= 1'b1;
                end else begin
                    r_blocked <= 1'b1;
                end
            end
        end
    end

    // Box offsets only need 5 bits; the in-box test rejects anything wider.
    assign w_col11   = {1'b0, i_Col_Count_Div};
    assign w_row11   = {1'b0, i_Row_Count_Div};
    assign w_col_ofs = 5'(i_Col_Count_Div - r_pos_x);
    assign w_row_ofs = 5'(i_Row_Count_Div - r_pos_y);
    assign w_in_box  = (w_col11 >= w_x11) && (w_col11 < w_x11 + c_SIZE_11) &&
                       (w_row11 >= w_y11) && (w_row11 < w_y11 + c_SIZE_11);

    frog_sprite_rom #(
        .c_SPRITE_SIZE(c_SPRITE_SIZE)
    ) u_sprite_rom (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Facing  (r_facing),
        .i_Row_Ofs (w_row_ofs),
        .i_Col_Ofs (w_col_ofs),
        .i_In_Box  (w_in_box),
        .o_Pixel   (w_pixel)
    );

    assign o_Pos_X   = r_pos_x;
    assign o_Pos_Y   = r_pos_y;
    assign o_Facing  = r_facing;
    assign o_Hop     = r_hop;
    assign o_Blocked = r_blocked;
    assign o_Draw    = w_pixel;

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Directed bench for frog_hop_ctrl with short hold/repeat timing (8/4 cycles).
module tb_frog_hop_ctrl;
    import frog_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] col;
    logic [9:0] row;
    logic       up, dn, lt, rt;
    logic       respawn;
    logic [9:0] pos_x, pos_y;
    logic [1:0] facing;
    logic       hop, blocked, draw;

    int n_checks = 0;
    int n_fails  = 0;

    // Independent copy of the upright frog; bit c of row r is pixel (r, c).
    logic [31:0] ref_bmp [32] = '{
        32'h03C003C0, 32'h07E007E0, 32'h0FF00FF0, 32'h0E700E70,
        32'h0FF00FF0, 32'h07FFFFE0, 32'h03FFFFC0, 32'h07FFFFE0,
        32'h0FFFFFF0, 32'h1FF00FF8, 32'h1FE007F8, 32'h3FFFFFFC,
        32'h3FFFFFFC, 32'h7FFFFFFE, 32'h7FFFFFFE, 32'h7FF81FFE,
        32'h7FF00FFE, 32'h7FFFFFFE, 32'h3FFFFFFC, 32'h3FFFFFFC,
        32'h1FFFFFF8, 32'h0FFFFFF0, 32'h67FFFFE6, 32'hF3FFFFCF,
        32'hF9FFFF9F, 32'hFCF00F3F, 32'h7E00007E, 32'h3F0000FC,
        32'h1F8001F8, 32'h0F0000F0, 32'h06000060, 32'h00000000
    };

    always #5 clk = ~clk;

    frog_hop_ctrl #(
        .c_HOLD_DELAY    (8),
        .c_REPEAT_PERIOD (4)
    ) dut (
        .i_Clk           (clk),
        .i_Rst           (rst),
        .i_Col_Count_Div (col),
        .i_Row_Count_Div (row),
        .i_Up            (up),
        .i_Dn            (dn),
        .i_Lt            (lt),
        .i_Rt            (rt),
        .i_Respawn       (respawn),
        .o_Pos_X         (pos_x),
        .o_Pos_Y         (pos_y),
        .o_Facing        (facing),
        .o_Hop           (hop),
        .o_Blocked       (blocked),
        .o_Draw          (draw)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Buttons as {rt, lt, dn, up}.
    task automatic set_btn(input logic [3:0] b);
        {rt, lt, dn, up} = b;
    endtask

    initial begin
        logic [31:0] bmp_row;
        int          r_ofs, c_ofs, exp_px;

        rst = 1'b1; respawn = 1'b0; col = '0; row = '0;
        set_btn(4'b0000);
        tick(); tick();
        $display("txn reset: pos=(%0d,%0d) facing=%0d", pos_x, pos_y, facing);
        check("rst_x", int'(pos_x), 304);
        check("rst_y", int'(pos_y), 448);
        check("rst_facing", int'(facing), 0);
        check("rst_hop", int'(hop), 0);
        check("rst_blocked", int'(blocked), 0);
        check("rst_draw", int'(draw), 0);
        rst = 1'b0;
        tick();
        check("rst_state", int'(dut.r_state), int'(S_IDLE));

        // Single up pulse
        set_btn(4'b0001); tick();
        $display("txn up pulse: y=%0d hop=%0d", pos_y, hop);
        check("up_y", int'(pos_y), 416);
        check("up_hop", int'(hop), 1);
        check("up_facing", int'(facing), 0);
        check("up_blocked", int'(blocked), 0);
        set_btn(4'b0000); tick();
        check("up_hop_end", int'(hop), 0);
        check("up_y_hold", int'(pos_y), 416);
        check("up_state_idle", int'(dut.r_state), int'(S_IDLE));

        // Hold right 20 cycles: hops at cycles 1, 9, 13, 17
        set_btn(4'b1000);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("rt_hold_hop_c%0d", k), int'(hop),
                  (k == 1 || k == 9 || k == 13 || k == 17) ? 1 : 0);
        end
        $display("txn right hold: x=%0d facing=%0d", pos_x, facing);
        check("rt_hold_x", int'(pos_x), 432);
        check("rt_hold_facing", int'(facing), 3);
        set_btn(4'b0000); tick();

        // Climb to the top row
        for (int k = 0; k < 13; k++) begin
            set_btn(4'b0001); tick();
            set_btn(4'b0000); tick();
        end
        check("climb_y", int'(pos_y), 0);
        set_btn(4'b0100); tick();
        check("pre_block_x", int'(pos_x), 400);
        check("pre_block_facing", int'(facing), 2);
        set_btn(4'b0000); tick();

        // Up at Y=0 is blocked
        set_btn(4'b0001); tick();
        $display("txn up at top: y=%0d blocked=%0d hop=%0d", pos_y, blocked, hop);
        check("top_blocked", int'(blocked), 1);
        check("top_hop", int'(hop), 0);
        check("top_y", int'(pos_y), 0);
        check("top_facing", int'(facing), 0);
        set_btn(4'b0000); tick();
        check("top_blocked_end", int'(blocked), 0);

        // Two buttons at once is no request
        set_btn(4'b0101);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("multi_hop_%0d", k), int'(hop), 0);
            check($sformatf("multi_blocked_%0d", k), int'(blocked), 0);
        end
        $display("txn up+left: pos=(%0d,%0d)", pos_x, pos_y);
        check("multi_x", int'(pos_x), 400);
        check("multi_state", int'(dut.r_state), int'(S_IDLE));
        set_btn(4'b0000); tick();

        // Left held, then switch to down
        set_btn(4'b0100); tick();
        check("lt_x", int'(pos_x), 368);
        check("lt_hop", int'(hop), 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("lt_wait_hop_%0d", k), int'(hop), 0);
        end
        set_btn(4'b0010); tick();
        $display("txn switch lt->dn: pos=(%0d,%0d) hop=%0d", pos_x, pos_y, hop);
        check("sw_y", int'(pos_y), 32);
        check("sw_hop", int'(hop), 1);
        check("sw_facing", int'(facing), 1);
        check("sw_x", int'(pos_x), 368);
        for (int j = 1; j <= 8; j++) begin
            tick();
            check($sformatf("sw_hold_hop_c%0d", j), int'(hop), (j == 8) ? 1 : 0);
        end
        check("sw_hold_y", int'(pos_y), 64);

        // Respawn on the cycle the next down hop would fire
        for (int j = 1; j <= 7; j++) tick();
        respawn = 1'b1; tick();
        respawn = 1'b0;
        $display("txn respawn: pos=(%0d,%0d) hop=%0d", pos_x, pos_y, hop);
        check("resp_x", int'(pos_x), 304);
        check("resp_y", int'(pos_y), 448);
        check("resp_hop", int'(hop), 0);
        check("resp_facing", int'(facing), 0);
        check("resp_state", int'(dut.r_state), int'(S_LOCK));
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("lock_hop_%0d", k), int'(hop), 0);
            check($sformatf("lock_blocked_%0d", k), int'(blocked), 0);
        end
        check("lock_y", int'(pos_y), 448);
        set_btn(4'b0000); tick();
        check("unlock_state", int'(dut.r_state), int'(S_IDLE));
        set_btn(4'b0010); tick();
        check("repress_blocked", int'(blocked), 1);
        check("repress_facing", int'(facing), 1);
        check("repress_y", int'(pos_y), 448);
        set_btn(4'b0000); tick();

        // Scan the box facing down: row-flipped bitmap, one cycle later
        for (int ry = 447; ry <= 480; ry++) begin
            for (int cx = 303; cx <= 336; cx++) begin
                row = 10'(ry);
                col = 10'(cx);
                tick();
                r_ofs = ry - 448;
                c_ofs = cx - 304;
                if (r_ofs >= 0 && r_ofs < 32 && c_ofs >= 0 && c_ofs < 32) begin
                    bmp_row = ref_bmp[31 - r_ofs];
                    exp_px  = int'(bmp_row[c_ofs]);
                end else begin
                    exp_px = 0;
                end
                check($sformatf("draw_r%0d_c%0d", ry, cx), int'(draw), exp_px);
            end
        end
        $display("txn draw scan facing down done");
        col = '0; row = '0; tick();
        check("draw_outside", int'(draw), 0);

`ifdef FROG_WRAP_X_EN
        for (int k = 1; k <= 11; k++) begin
            set_btn(4'b1000); tick();
            check($sformatf("wrap_rt_hop_%0d", k), int'(hop), 1);
            if (k == 10) check("wrap_rt_x_last", int'(pos_x), 624);
            set_btn(4'b0000); tick();
        end
        check("wrap_rt_x0", int'(pos_x), 0);
        set_btn(4'b0100); tick();
        $display("txn wrap left: x=%0d hop=%0d", pos_x, hop);
        check("wrap_lt_x", int'(pos_x), 608);
        check("wrap_lt_hop", int'(hop), 1);
        set_btn(4'b0000); tick();
`else
        for (int k = 1; k <= 10; k++) begin
            set_btn(4'b1000); tick();
            check($sformatf("clamp_rt_hop_%0d", k), int'(hop), (k <= 9) ? 1 : 0);
            check($sformatf("clamp_rt_blk_%0d", k), int'(blocked), (k == 10) ? 1 : 0);
            set_btn(4'b0000); tick();
        end
        $display("txn right clamp: x=%0d", pos_x);
        check("clamp_rt_x", int'(pos_x), 592);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
